// File: rtl/core_ctrl_pkg.sv
// Shared core-control definitions: GPR index width, datapath width and the x0 index.
package core_ctrl_pkg;

    localparam int unsigned GPR_IDX_W = 5;
    localparam int unsigned XLEN      = 32;

    localparam logic [GPR_IDX_W-1:0] GPR_ZERO = 5'd0;

endpackage

// File: rtl/core_ctrl_rr_arb.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping modulo NUM_SRC.
module core_ctrl_rr_arb #(
    parameter int unsigned NUM_SRC = 3,
    parameter int unsigned PTR_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] gnt,
    output logic [PTR_W-1:0]   gnt_idx
);

    logic        found;
    int unsigned j;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            // ptr is always < NUM_SRC, so a single subtraction is enough to wrap
            j = 32'(ptr) + k;
            if (j >= NUM_SRC) begin
                j = j - NUM_SRC;
            end
            if (!found && req[j]) begin
                found   = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/core_ctrl_wb_retire.sv
// Writeback/retire stage: arbitrates completing units, drives the regfile write
// port and the scoreboard retire port one cycle after accept, and counts retires.
module core_ctrl_wb_retire
    import core_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SRC = 3,
    parameter int unsigned CNT_W   = 64
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [NUM_SRC-1:0]             wb_src_valid,
    output logic [NUM_SRC-1:0]             wb_src_ready,
    input  logic [NUM_SRC*GPR_IDX_W-1:0]   wb_src_rd_idx,
    input  logic [NUM_SRC*XLEN-1:0]        wb_src_data,
    output logic                           scb_ret_reg_valid,
    output logic [GPR_IDX_W-1:0]           scb_ret_reg_idx,
    output logic                           gpr_wr_en,
    output logic [GPR_IDX_W-1:0]           gpr_wr_idx,
    output logic [XLEN-1:0]                gpr_wr_data,
    output logic [CNT_W-1:0]               ret_cnt
);

    localparam int unsigned PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     gnt_idx;
    logic [PTR_W-1:0]     next_ptr;
    logic [NUM_SRC-1:0]   gnt;
    logic                 accept;
    logic [GPR_IDX_W-1:0] sel_rd;
    logic [XLEN-1:0]      sel_data;

    core_ctrl_rr_arb #(
        .NUM_SRC (NUM_SRC),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req     (wb_src_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign wb_src_ready = gnt;
    assign accept       = |gnt;
    assign next_ptr     = (gnt_idx == PTR_W'(NUM_SRC - 1)) ? '0 : gnt_idx + PTR_W'(1);

    // gnt is one-hot or zero, so an AND-OR mux selects the winner's payload
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (gnt[i]) begin
                sel_rd   = sel_rd   | wb_src_rd_idx[i*GPR_IDX_W +: GPR_IDX_W];
                sel_data = sel_data | wb_src_data[i*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr            <= '0;
            scb_ret_reg_valid <= 1'b0;
            scb_ret_reg_idx   <= '0;
            gpr_wr_en         <= 1'b0;
            gpr_wr_idx        <= '0;
            gpr_wr_data       <= '0;
            ret_cnt           <= '0;
        end else begin
            scb_ret_reg_valid <= accept;
            // x0 still retires so its scoreboard entry clears, but never writes the regfile
            gpr_wr_en         <= accept && (sel_rd != GPR_ZERO);
            if (accept) begin
                rr_ptr          <= next_ptr;
                scb_ret_reg_idx <= sel_rd;
                gpr_wr_idx      <= sel_rd;
                gpr_wr_data     <= sel_data;
                ret_cnt         <= ret_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_core_ctrl_wb_retire.sv
// Directed self-checking bench for core_ctrl_wb_retire with NUM_SRC=3.
module tb_core_ctrl_wb_retire;

    localparam int unsigned NUM_SRC = 3;
    localparam int unsigned CNT_W   = 64;

    logic                 clk;
    logic                 rstn;
    logic [NUM_SRC-1:0]   wb_src_valid;
    logic [NUM_SRC-1:0]   wb_src_ready;
    logic [NUM_SRC*5-1:0] wb_src_rd_idx;
    logic [NUM_SRC*32-1:0] wb_src_data;
    logic                 scb_ret_reg_valid;
    logic [4:0]           scb_ret_reg_idx;
    logic                 gpr_wr_en;
    logic [4:0]           gpr_wr_idx;
    logic [31:0]          gpr_wr_data;
    logic [CNT_W-1:0]     ret_cnt;

    int unsigned n_chk;
    int unsigned n_pass;

    core_ctrl_wb_retire #(
        .NUM_SRC (NUM_SRC),
        .CNT_W   (CNT_W)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .wb_src_valid      (wb_src_valid),
        .wb_src_ready      (wb_src_ready),
        .wb_src_rd_idx     (wb_src_rd_idx),
        .wb_src_data       (wb_src_data),
        .scb_ret_reg_valid (scb_ret_reg_valid),
        .scb_ret_reg_idx   (scb_ret_reg_idx),
        .gpr_wr_en         (gpr_wr_en),
        .gpr_wr_idx        (gpr_wr_idx),
        .gpr_wr_data       (gpr_wr_data),
        .ret_cnt           (ret_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int unsigned i, input logic [4:0] rd, input logic [31:0] data);
        wb_src_rd_idx[i*5 +: 5]   = rd;
        wb_src_data[i*32 +: 32]   = data;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_retire(input string tag, input logic [4:0] idx, input logic [31:0] data,
                              input logic wen, input logic [63:0] cnt);
        chk({tag, "_valid"}, 64'(scb_ret_reg_valid), 64'd1);
        chk({tag, "_scb_idx"}, 64'(scb_ret_reg_idx), 64'(idx));
        chk({tag, "_wr_idx"}, 64'(gpr_wr_idx), 64'(idx));
        chk({tag, "_wr_en"}, 64'(gpr_wr_en), 64'(wen));
        chk({tag, "_wr_data"}, 64'(gpr_wr_data), 64'(data));
        chk({tag, "_cnt"}, ret_cnt, cnt);
    endtask

    logic [4:0]  cont_rd   [3];
    logic [31:0] cont_data [3];

    initial begin
        n_chk         = 0;
        n_pass        = 0;
        rstn          = 1'b0;
        wb_src_valid  = '0;
        wb_src_rd_idx = '0;
        wb_src_data   = '0;
        cont_rd       = '{5'd1, 5'd2, 5'd4};
        cont_data     = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0004};

        #22;
        rstn = 1'b1;
        next_cycle();

        // idle after reset
        for (int i = 0; i < 10; i++) begin
            chk("idle_ready", 64'(wb_src_ready), 64'd0);
            chk("idle_valid", 64'(scb_ret_reg_valid), 64'd0);
            next_cycle();
        end
        chk("idle_wr_en", 64'(gpr_wr_en), 64'd0);
        chk("idle_idx", 64'(scb_ret_reg_idx), 64'd0);
        chk("idle_wr_idx", 64'(gpr_wr_idx), 64'd0);
        chk("idle_data", 64'(gpr_wr_data), 64'd0);
        chk("idle_cnt", ret_cnt, 64'd0);

        // single source 1 (ptr 0 -> 2)
        set_src(1, 5'd7, 32'hDEAD_BEEF);
        wb_src_valid = 3'b010;
        #1;
        chk("single_ready", 64'(wb_src_ready), 64'b010);
        next_cycle();
        wb_src_valid = '0;
        chk_retire("single", 5'd7, 32'hDEAD_BEEF, 1'b1, 64'd1);
        next_cycle();
        chk("single_idle_valid", 64'(scb_ret_reg_valid), 64'd0);
        chk("single_idle_wr_en", 64'(gpr_wr_en), 64'd0);
        chk("single_hold_idx", 64'(gpr_wr_idx), 64'd7);
        chk("single_hold_data", 64'(gpr_wr_data), 64'hDEAD_BEEF);

        // x0 retire from src0 (ptr 2 -> wrap to src0 -> ptr 1)
        set_src(0, 5'd0, 32'h0000_1234);
        wb_src_valid = 3'b001;
        #1;
        chk("x0_ready", 64'(wb_src_ready), 64'b001);
        next_cycle();
        wb_src_valid = '0;
        chk_retire("x0", 5'd0, 32'h0000_1234, 1'b0, 64'd2);

        // src0 and src2 with ptr 1: src2 wins, src0 holds and wins next
        set_src(0, 5'd3, 32'h3333_0000);
        set_src(2, 5'd5, 32'h5555_0000);
        wb_src_valid = 3'b101;
        #1;
        chk("loss_ready0", 64'(wb_src_ready), 64'b100);
        next_cycle();
        wb_src_valid = 3'b001;
        chk_retire("loss_first", 5'd5, 32'h5555_0000, 1'b1, 64'd3);
        chk("loss_ready1", 64'(wb_src_ready), 64'b001);
        next_cycle();
        wb_src_valid = '0;
        chk_retire("loss_second", 5'd3, 32'h3333_0000, 1'b1, 64'd4);

        // src2 alone (ptr 1 -> 0) to start contention at ptr 0
        set_src(2, 5'd10, 32'h0000_000A);
        wb_src_valid = 3'b100;
        next_cycle();
        wb_src_valid = '0;
        chk_retire("align", 5'd10, 32'h0000_000A, 1'b1, 64'd5);

        // contention: all valid for 6 cycles, grants 0,1,2,0,1,2
        for (int unsigned s = 0; s < 3; s++) begin
            set_src(s, cont_rd[s], cont_data[s]);
        end
        wb_src_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("cont_ready", 64'(wb_src_ready), 64'(3'b001 << (k % 3)));
            next_cycle();
            chk_retire("cont", cont_rd[k % 3], cont_data[k % 3], 1'b1, 64'(6 + k));
        end
        wb_src_valid = '0;
        next_cycle();
        chk("cont_end_valid", 64'(scb_ret_reg_valid), 64'd0);
        chk("cont_end_cnt", ret_cnt, 64'd11);

        // src0 accept moves ptr to 1 so the reset test can see ptr return to 0
        set_src(0, 5'd12, 32'h0000_000C);
        wb_src_valid = 3'b001;
        next_cycle();
        wb_src_valid = '0;
        chk_retire("pre_rst", 5'd12, 32'h0000_000C, 1'b1, 64'd12);

        // reset mid-operation: src1 presented, reset before the edge
        set_src(1, 5'd9, 32'h9999_9999);
        wb_src_valid = 3'b010;
        #1;
        chk("rst_ready", 64'(wb_src_ready), 64'b010);
        rstn         = 1'b0;
        wb_src_valid = '0;
        next_cycle();
        chk("rst_valid", 64'(scb_ret_reg_valid), 64'd0);
        chk("rst_wr_en", 64'(gpr_wr_en), 64'd0);
        chk("rst_idx", 64'(scb_ret_reg_idx), 64'd0);
        chk("rst_data", 64'(gpr_wr_data), 64'd0);
        chk("rst_cnt", ret_cnt, 64'd0);
        rstn = 1'b1;
        next_cycle();
        chk("rst_no_retire", 64'(scb_ret_reg_valid), 64'd0);
        set_src(0, 5'd6, 32'h6666_0000);
        wb_src_valid = 3'b011;
        #1;
        chk("rst_ptr0_ready", 64'(wb_src_ready), 64'b001);
        next_cycle();
        wb_src_valid = '0;
        chk_retire("post_rst", 5'd6, 32'h6666_0000, 1'b1, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/core_ctrl_wb_retire.md
Name: core_ctrl_wb_retire

Overview:
Retire/writeback end of the GPR scoreboard protocol. It collects completed results from NUM_SRC execution units (ALU, LSU, MUL/DIV, ...) and round-robin arbitrates among them, one retire per cycle. Each cycle it drives the register-file write port and the scoreboard retire port (scb_ret_reg_valid / scb_ret_reg_idx), which clears the busy bit set at emit time. It also keeps a retired-instruction counter.

Parameters:
NUM_SRC, 3, number of completing execution units (range 2..8).
CNT_W, 64, width of the retired-instruction counter.

Ports:
clk  input  1  core clock; all state updates on its rising edge.
rstn  input  1  reset, asynchronous, active-low.
wb_src_valid  input  NUM_SRC  per-source completion valid; bit i = source i.
wb_src_ready  output  NUM_SRC  per-source grant/accept, one-hot or zero.
wb_src_rd_idx  input  NUM_SRC*5  packed destination GPR index; source i at bits [5i+4:5i].
wb_src_data  input  NUM_SRC*32  packed result data; source i at bits [32i+31:32i].
scb_ret_reg_valid  output  1  retire strobe to the scoreboard.
scb_ret_reg_idx  output  5  GPR index whose busy bit is cleared.
gpr_wr_en  output  1  register-file write enable.
gpr_wr_idx  output  5  register-file write index.
gpr_wr_data  output  32  register-file write data.
ret_cnt  output  CNT_W  number of retires since reset.

Behaviour:
- Reset (rstn low, asynchronous): scb_ret_reg_valid=0, scb_ret_reg_idx=0, gpr_wr_en=0, gpr_wr_idx=0, gpr_wr_data=0, ret_cnt=0, rr_ptr=0. wb_src_ready is combinational and is 0 while no source is valid.
- Handshake: a transfer occurs when wb_src_valid[i] and wb_src_ready[i] are both 1. A source holds valid, rd_idx and data stable until accepted. A source's valid must not depend on its ready.
- Arbitration (combinational): grant = first i with wb_src_valid[i]=1, scanning from rr_ptr upward and wrapping modulo NUM_SRC. wb_src_ready = one-hot(grant), or all-zero if no source is valid. At most one accept per cycle.
- rr_ptr: on an accept of source g, rr_ptr <= (g+1) mod NUM_SRC at the clock edge. With no accept, rr_ptr holds. Wrap from NUM_SRC-1 to 0.
- Output stage: registered, latency 1. The cycle after an accept: scb_ret_reg_valid=1, scb_ret_reg_idx=gpr_wr_idx=rd_idx, gpr_wr_data=data, gpr_wr_en=(rd_idx!=0). With no accept: scb_ret_reg_valid=0 and gpr_wr_en=0; idx/data hold their last values.
- x0: rd_idx=0 still retires (scb_ret_reg_valid=1, idx 0) so the scoreboard entry clears. gpr_wr_en=0.
- The output stage never stalls. Downstream (scoreboard, regfile) always accepts, so throughput is 1 retire/cycle.
- Same rd from two sources: serialized by the arbiter; the later grant writes last. No merging.
- ret_cnt increments by 1 in every cycle scb_ret_reg_valid=1 (registered alongside the output stage) and wraps to 0 after 2^CNT_W-1.
- Reset mid-operation: any pending output is dropped and no retire is emitted. Sources must re-present after reset.

Decomposition:
- Shared package core_ctrl_pkg: GPR_IDX_W=5, XLEN=32, GPR_ZERO=5'd0.
- One sub-module, core_ctrl_rr_arb. Inputs: req[NUM_SRC], ptr. Outputs: one-hot gnt, encoded gnt_idx. Purely combinational. rr_ptr register and output stage stay in core_ctrl_wb_retire.

Test Plan:
- Reset then idle: wb_src_valid=0 for 10 cycles -> all outputs 0, ret_cnt=0, wb_src_ready=0.
- Single source: src1 valid, rd=7, data=0xDEADBEEF -> ready[1]=1 in the same cycle. Next cycle: scb_ret_reg_valid=1, idx=7, gpr_wr_en=1, data=0xDEADBEEF, ret_cnt=1.
- Contention, NUM_SRC=3: all three valid continuously for 6 cycles from rr_ptr=0 -> grants 0,1,2,0,1,2; six retires back-to-back; ret_cnt=6.
- x0 retire: src0 valid, rd=0, data=0x1234 -> next cycle scb_ret_reg_valid=1, idx=0, gpr_wr_en=0.
- Hold under loss: src0 and src2 valid with rr_ptr=1 -> src2 granted first; src0 holds rd=3 and is granted the next cycle; retires for idx 5 then 3 (src2 rd=5).
- Reset mid-operation: accept src1 rd=9, assert rstn low before the next edge -> no retire appears, ret_cnt=0, rr_ptr=0.
